// File: rtl/spi_reg_config.sv
// spi_reg_config: write-only SPI Mode-0 peripheral that commits 16-bit frames
// into a five-entry configuration register file for the PWM/output datapath.
//
// Ports:
//   clk             system clock
//   rst_n           synchronous active-low reset
//   sclk, copi, ncs SPI pins from the controller, asynchronous to clk
//   en_reg_out_7_0  reg 0x00, output enables uo_out[7:0]
//   en_reg_out_15_8 reg 0x01, output enables uio_out[7:0]
//   en_reg_pwm_7_0  reg 0x02, PWM-mode enables uo_out[7:0]
//   en_reg_pwm_15_8 reg 0x03, PWM-mode enables uio_out[7:0]
//   pwm_duty_cycle  reg 0x04, shared duty cycle
//
// Frame: MSB first, bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
module spi_reg_config #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] copi_sync_q;
   logic [SYNC_STAGES-1:0] ncs_sync_q;
   logic                   sclk_prev_q;
   logic                   ncs_prev_q;

   logic sclk_s, copi_s, ncs_s;
   logic sclk_rise, ncs_fall, ncs_rise;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] shift_q, shift_d;
   logic        commit;

   logic [7:0] reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign copi_s = copi_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign ncs_fall  = ~ncs_s & ncs_prev_q;
   assign ncs_rise  = ncs_s & ~ncs_prev_q;

   // ncs chain resets to the idle (high) level so a still-low pin after reset
   // shows up as a fresh falling edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '1;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
         ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
         sclk_prev_q <= sclk_s;
         ncs_prev_q  <= ncs_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      commit  = 1'b0;
      case (state_q)
         StIdle: begin
            if (ncs_fall) begin
               state_d = StShift;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         StShift: begin
            // End of frame takes priority over any coincident sclk edge.
            if (ncs_rise) begin
               state_d = StIdle;
               commit  = (cnt_q == 5'd16) && shift_q[15] &&
                         ({25'd0, shift_q[14:8]} <= MAX_ADDR);
            end else if (sclk_rise) begin
               shift_d = {shift_q[14:0], copi_s};
               // Saturating at 17 keeps over-long frames distinguishable from 16.
               if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg0_q <= '0;
         reg1_q <= '0;
         reg2_q <= '0;
         reg3_q <= '0;
         reg4_q <= '0;
      end else if (commit) begin
         case (shift_q[14:8])
            7'd0:    reg0_q <= shift_q[7:0];
            7'd1:    reg1_q <= shift_q[7:0];
            7'd2:    reg2_q <= shift_q[7:0];
            7'd3:    reg3_q <= shift_q[7:0];
            7'd4:    reg4_q <= shift_q[7:0];
            default: ;
         endcase
      end
   end

   assign en_reg_out_7_0  = reg0_q;
   assign en_reg_out_15_8 = reg1_q;
   assign en_reg_pwm_7_0  = reg2_q;
   assign en_reg_pwm_15_8 = reg3_q;
   assign pwm_duty_cycle  = reg4_q;

endmodule

// File: tb/tb_spi_reg_config.sv
// tb_spi_reg_config: drives SPI frames into spi_reg_config and compares the
// register file against a behavioural model (array indexed by address).
module tb_spi_reg_config;

   logic       clk;
   logic       rst_n;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [7:0]  model [5];

   spi_reg_config dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".r0"}, en_reg_out_7_0,  model[0]);
      check({tag, ".r1"}, en_reg_out_15_8, model[1]);
      check({tag, ".r2"}, en_reg_pwm_7_0,  model[2]);
      check({tag, ".r3"}, en_reg_pwm_15_8, model[3]);
      check({tag, ".r4"}, pwm_duty_cycle,  model[4]);
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model of the commit rule: only exact 16-bit writes to a valid address land.
   task automatic model_frame(input logic [31:0] value, input int n);
      if (n == 16 && value[15] && value[14:8] <= 7'd4) model[value[10:8]] = value[7:0];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
   endtask

   // Shifts the n low bits of value out MSB first; sclk phases of 5 clk each.
   task automatic shift_bits(input logic [31:0] value, input int n, input int first);
      for (int i = first; i < n; i++) begin
         copi = value[n-1-i];
         clks(5);
         sclk = 1'b1;
         clks(5);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [31:0] value, input int n);
      ncs = 1'b0;
      clks(4);
      shift_bits(value, n, 0);
      clks(4);
      ncs = 1'b1;
      model_frame(value, n);
   endtask

   task automatic frame_wait(input logic [31:0] value, input int n, input string tag);
      frame(value, n);
      clks(4);
      check_all(tag);
   endtask

   initial begin
      logic [31:0] v;
      int          n;
      logic [7:0]  prev;

      rst_n = 1'b0;
      sclk  = 1'b0;
      copi  = 1'b0;
      ncs   = 1'b1;
      model_reset();
      clks(3);
      check_all("reset");
      rst_n = 1'b1;
      clks(3);

      // Latency: not yet at the 2nd edge after ncs rises, present at the 3rd.
      frame(32'h80F0, 16);
      clks(2);
      check("lat.early", en_reg_out_7_0, 8'h00);
      clks(1);
      check("lat.edge3", en_reg_out_7_0, 8'hF0);
      clks(2);
      check_all("w00");

      frame_wait(32'h81AA, 16, "w01");
      frame_wait(32'h8255, 16, "w02");
      frame_wait(32'h83C3, 16, "w03");
      frame_wait(32'h8480, 16, "w04");
      check("w04.dir", pwm_duty_cycle, 8'h80);

      frame_wait(32'h00FF, 16, "read");
      frame_wait(32'hB012, 16, "badaddr");
      frame_wait(32'h8411 >> 1, 15, "short");
      frame_wait({15'd0, 16'h8411, 1'b0}, 17, "long");
      check("long.dir", pwm_duty_cycle, 8'h80);
      frame_wait(32'h8411, 16, "w04b");
      check("w04b.dir", pwm_duty_cycle, 8'h11);

      // Reset pulse after 8 bits; remainder of the frame must be discarded.
      ncs = 1'b0;
      clks(4);
      shift_bits(32'h80FF, 16, 8);
      rst_n = 1'b0;
      clks(1);
      rst_n = 1'b1;
      model_reset();
      shift_bits(32'h00FF, 8, 0);
      clks(4);
      ncs = 1'b1;
      clks(4);
      check_all("midrst");
      frame_wait(32'h8001, 16, "postrst");
      check("postrst.dir", en_reg_out_7_0, 8'h01);

      // Back-to-back frames with a 2-cycle ncs-high gap.
      frame(32'h8433, 16);
      clks(2);
      ncs = 1'b0;
      clks(1);
      check("b2b.first", pwm_duty_cycle, 8'h33);
      clks(3);
      shift_bits(32'h8434, 16, 0);
      clks(4);
      ncs = 1'b1;
      model_frame(32'h8434, 16);
      clks(4);
      check("b2b.second", pwm_duty_cycle, 8'h34);
      check_all("b2b");

      // Randomized frames: address mostly in range, mixed R/W and lengths.
      for (int k = 0; k < 40; k++) begin
         v = 32'($urandom);
         v[15] = ($urandom_range(0, 3) != 0);
         v[14:8] = ($urandom_range(0, 4) != 0) ? 7'($urandom_range(0, 4))
                                              : 7'($urandom_range(5, 127));
         case ($urandom_range(0, 5))
            0:       n = 15;
            1:       n = 17;
            default: n = 16;
         endcase
         if (n == 17) v = {v[30:0], 1'b1};
         else if (n == 15) v = {17'd0, v[15:1]};
         else v = {16'd0, v[15:0]};
         prev = model[4];
         frame_wait(v, n, $sformatf("rnd%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_reg_config.md
Name: spi_reg_config

Overview:
- SPI Mode-0 peripheral, write-only. Receives 16-bit frames from an external controller on ui_in pins and commits them into a small register file.
- The register file configures the PWM/output datapath: output enables, PWM enables and a shared duty cycle.
- Sits inside tt_um_uwasic_onboarding_Joe_Ji, between the ui_in SPI pins and the PWM peripheral.
- SPI pins are asynchronous to clk and are oversampled in the clk domain.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk/copi/ncs (minimum 2).
- MAX_ADDR, 4, highest valid register address; writes above it are discarded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- sclk  input  1  SPI clock from controller (async)
- copi  input  1  SPI data, controller-out/peripheral-in (async)
- ncs  input  1  SPI chip select, active low (async)
- en_reg_out_7_0  output  8  reg 0x00, output enables uo_out[7:0]
- en_reg_out_15_8  output  8  reg 0x01, output enables uio_out[7:0]
- en_reg_pwm_7_0  output  8  reg 0x02, PWM-mode enables uo_out[7:0]
- en_reg_pwm_15_8  output  8  reg 0x03, PWM-mode enables uio_out[7:0]
- pwm_duty_cycle  output  8  reg 0x04, duty (0x00 = 0%, 0xFF = always high)

Behaviour:
- Reset:
  - rst_n sampled low on a clk edge clears all five registers to 0x00.
  - It also clears synchronizer flops (ncs chain to 1, others to 0), shift register, bit counter and the in-frame flag.
- Synchronizers: each of sclk, copi, ncs passes through SYNC_STAGES flops, plus one history flop for edge detection.
- Edges are defined on synchronized values:
  - sclk_rise = cur 1, prev 0.
  - ncs_fall = cur 0, prev 1.
  - ncs_rise = cur 1, prev 0.
- Timing requirement on the controller: sclk high and low phases each ≥ 4 clk periods. copi is stable across the sclk rising edge, i.e. sampled on the same synchronized edge.
- Frame format, MSB first, 16 bits:
  - bit15 = R/W (1 = write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- States: IDLE, SHIFT.
  - IDLE: ncs_fall → SHIFT; clear bit counter (5-bit) and shift register (16-bit). sclk edges in IDLE are ignored.
  - SHIFT: each sclk_rise shifts synchronized copi into the shift-register LSB. The bit counter increments and saturates at 17.
  - SHIFT: ncs_rise → commit check, then IDLE.
- Commit check, applied on the clk edge where ncs_rise is detected. The write happens only if all three hold:
  - bit counter == 16,
  - bit15 == 1,
  - address ≤ MAX_ADDR.
  - If all hold, the addressed register takes data[7:0] on that same edge.
  - Otherwise, nothing changes.
- Latency: a register updates SYNC_STAGES+1 clk edges after the first clk edge that samples the ncs pin high, i.e. 3 clk edges for the default.
- Boundary cases:
  - Short frame (<16 bits) or long frame (>16 bits; counter saturates) → discarded, no register change.
  - Read frame (bit15 = 0) → discarded; this block drives no read-back data.
  - Address 0x05–0x7F → discarded.
  - ncs_fall and ncs_rise cannot coincide (single synchronized signal). A glitch on ncs shorter than the sampling period may be missed; this is acceptable.
  - Reset asserted mid-frame → state forced to IDLE, registers 0x00.
    - If ncs is still low when reset releases, the synchronizer chain comes up at 1 and sees ncs low, so a false ncs_fall is detected and a new frame starts mid-transfer.
    - That frame's bit count will be wrong (≠16), so it is discarded. The first following complete frame commits normally.
  - Back-to-back frames with ncs high ≥ 2 clk periods between them → each frame is evaluated independently.
- Outputs are registered, glitch-free and change only at a commit or at reset.

Test Plan:
- Reset, then full write frame 0x80F0 (write, addr 0x00, data 0xF0) → en_reg_out_7_0 = 0xF0 three clk edges after ncs rises; all other registers remain 0x00.
- Writes 0x81AA, 0x8255, 0x83C3, 0x8480 → regs 0x01..0x04 = 0xAA, 0x55, 0xC3, 0x80 respectively; reg 0x00 is unchanged.
- Read frame 0x00FF, then invalid-address frame 0xB012 (addr 0x30) → no register changes.
- 15-bit frame and 17-bit frame, each carrying write addr 0x04 data 0x11 → pwm_duty_cycle stays at its prior value. The next valid frame 0x8411 → 0x11.
- Assert rst_n low for 1 cycle after 8 bits of frame 0x80FF → all registers 0x00; the remainder of that frame is discarded; a following frame 0x8001 → en_reg_out_7_0 = 0x01.
- Two back-to-back frames 0x8433 then 0x8434, with ncs high for 2 clk periods between them → pwm_duty_cycle goes 0x33 then 0x34, with no lost frame.
